cfg_readback_ctrl: RTL and testbench

- Reads back the fabric configuration memory one wordline at a time. It is the read-side counterpart of the bitline/wordline bitstream load path.
- For each row it asserts one wordline, waits for the bitline sense values to settle, captures them, and streams the row out as OUT_W-bit words over a valid/ready interface.
- Sits beside the fabric on bl_config_region_0/wl_config_region_0. Used by bitstream verification benches and by the on-chip debug path.

---
 rtl/cfg_readback_ctrl.sv | 159 +++++++++++++++
 tb/tb_cfg_readback_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_readback_ctrl.sv
// Configuration memory readback: asserts one wordline at a time, captures the
// bitline sense values and streams each row out as OUT_W-bit words.
module cfg_readback_ctrl #(
  parameter int NUM_BL        = 514,
  parameter int NUM_WL        = 407,
  parameter int OUT_W         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              global_resetn,
  input  logic              start,
  input  logic              abort,
  output logic [NUM_WL-1:0] wl_sel,
  output logic              wl_rd_en,
  input  logic [NUM_BL-1:0] bl_sense,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  checksum
);

  localparam int WPR    = (NUM_BL + OUT_W - 1) / OUT_W;
  localparam int CAP_W  = WPR * OUT_W;
  localparam int ROW_W  = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;
  localparam int WORD_W = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(NUM_WL - 1);
  localparam logic [WORD_W-1:0] LAST_WORD   = WORD_W'(WPR - 1);
  localparam logic [SET_W-1:0]  LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_SHIFT
  } state_e;

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [CAP_W-1:0]    cap_q, cap_d;
  logic [OUT_W-1:0]    checksum_q, checksum_d;
  logic                done_q, done_d;

  logic [OUT_W-1:0]    cap_words [WPR];
  logic [OUT_W-1:0]    cur_word;

  // The capture register is padded to a whole number of words; the MSB padding is always zero.
  for (genvar k = 0; k < WPR; k++) begin : g_words
    assign cap_words[k] = cap_q[k*OUT_W +: OUT_W];
  end

  assign cur_word = cap_words[word_q];

  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      word_q     <= '0;
      settle_q   <= '0;
      cap_q      <= '0;
      checksum_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      word_q     <= word_d;
      settle_q   <= settle_d;
      cap_q      <= cap_d;
      checksum_q <= checksum_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    word_d     = word_q;
    settle_d   = settle_q;
    cap_d      = cap_q;
    checksum_d = checksum_q;
    done_d     = 1'b0;

    // Abort beats start and any same-cycle handshake; the partial checksum is kept.
    if (abort) begin
      state_d  = S_IDLE;
      row_d    = '0;
      word_d   = '0;
      settle_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d    = S_ASSERT;
            row_d      = '0;
            word_d     = '0;
            settle_d   = '0;
            checksum_d = '0;
          end
        end
        S_ASSERT: begin
          if (settle_q == LAST_SETTLE) begin
            cap_d    = CAP_W'(bl_sense);
            settle_d = '0;
            state_d  = S_SHIFT;
          end else begin
            settle_d = settle_q + SET_W'(1);
          end
        end
        S_SHIFT: begin
          if (out_ready) begin
            checksum_d = checksum_q ^ cur_word;
            if (word_q == LAST_WORD) begin
              word_d = '0;
              if (row_q == LAST_ROW) begin
                row_d   = '0;
                state_d = S_IDLE;
                done_d  = 1'b1;
              end else begin
                row_d   = row_q + ROW_W'(1);
                state_d = S_ASSERT;
              end
            end else begin
              word_d = word_q + WORD_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from the async-reset state so the wordline drops with reset.
  always_comb begin
    wl_sel    = '0;
    wl_rd_en  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    if (state_q == S_ASSERT) begin
      wl_sel[row_q] = 1'b1;
      wl_rd_en      = 1'b1;
    end
    if (state_q == S_SHIFT) begin
      out_valid = 1'b1;
      out_data  = cur_word;
      out_last  = (word_q == LAST_WORD) && (row_q == LAST_ROW);
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign checksum = checksum_q;

endmodule

// File: tb/tb_cfg_readback_ctrl.sv
// Scoreboard bench for cfg_readback_ctrl on a 10x3 array with 4-bit output words.
module tb_cfg_readback_ctrl;

  localparam int NUM_BL = 10;
  localparam int NUM_WL = 3;
  localparam int OUT_W  = 4;
  localparam int SETTLE = 2;

  logic              clk = 1'b0;
  logic              global_resetn;
  logic              start;
  logic              abort;
  logic [NUM_WL-1:0] wl_sel;
  logic              wl_rd_en;
  logic [NUM_BL-1:0] bl_sense;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [OUT_W-1:0]  checksum;

  // Rows 0x2A5, 0x3FF, 0x001 split into 4-bit words, LSB word first.
  logic [3:0] exp_words [9] = '{4'h5, 4'hA, 4'h2, 4'hF, 4'hF, 4'h3, 4'h1, 4'h0, 4'h0};
  // 5^A^2^F^F^3^1^0^0
  localparam logic [3:0] FULL_CSUM = 4'hF;
  // 5^A^2
  localparam logic [3:0] ROW0_CSUM = 4'hD;

  int vectors    = 0;
  int miscompares = 0;

  logic [4:0] exp_q [$];
  logic       done_pending = 1'b0;
  logic       prev_stall = 1'b0;
  logic [3:0] prev_data = '0;
  logic       prev_last = 1'b0;
  logic       bp_mode = 1'b0;

  cfg_readback_ctrl #(
    .NUM_BL(NUM_BL), .NUM_WL(NUM_WL), .OUT_W(OUT_W), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .global_resetn(global_resetn), .start(start), .abort(abort),
    .wl_sel(wl_sel), .wl_rd_en(wl_rd_en), .bl_sense(bl_sense),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Config array model: the selected row appears on the bitlines, junk otherwise.
  always_comb begin
    case (wl_sel)
      3'b001:  bl_sense = 10'h2A5;
      3'b010:  bl_sense = 10'h3FF;
      3'b100:  bl_sense = 10'h001;
      default: bl_sense = 10'h2CC;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the first n expected words of a full readback, then pulse start.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == 8), exp_words[i]});
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 2000) begin
      tick();
      n++;
    end
    checkOutput({name, " done seen"}, 32'(done), 32'd1);
  endtask

  task automatic wait_row1(input string name);
    int n = 0;
    while (wl_sel != 3'b010 && n < 200) begin
      tick();
      n++;
    end
    checkOutput({name, " reached row 1"}, 32'(wl_sel), 32'h2);
  endtask

  // Backpressure generator
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) out_ready = ($urandom_range(0, 99) < 30);
    end
  end

  // Monitor: scoreboard pops, stall stability, done pulse and wordline invariants.
  always @(negedge clk) begin
    if (!global_resetn) begin
      prev_stall   = 1'b0;
      done_pending = 1'b0;
    end else begin
      checkOutput("wl_sel onehot0", 32'($onehot0(wl_sel)), 32'd1);
      checkOutput("wl_sel with out_valid", 32'((|wl_sel) && out_valid), 32'd0);
      if (done_pending) begin
        checkOutput("done after last", 32'(done), 32'd1);
        done_pending = 1'b0;
      end else if (done) begin
        checkOutput("spurious done", 32'(done), 32'd0);
      end
      if (prev_stall) begin
        checkOutput("stall valid held", 32'(out_valid), 32'd1);
        checkOutput("stall data held", 32'(out_data), 32'(prev_data));
        checkOutput("stall last held", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready && !abort) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected word", 32'(out_data), 32'hDEAD);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          checkOutput("out_data", 32'(out_data), 32'(e[3:0]));
          checkOutput("out_last", 32'(out_last), 32'(e[4]));
          if (e[4]) done_pending = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready && !abort;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    global_resetn = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    out_ready     = 1'b1;
    #12;
    checkOutput("reset wl_sel", 32'(wl_sel), 32'd0);
    checkOutput("reset wl_rd_en", 32'(wl_rd_en), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", 32'(out_data), 32'd0);
    checkOutput("reset out_last", 32'(out_last), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset checksum", 32'(checksum), 32'd0);
    tick();
    global_resetn = 1'b1;
    tick();

    $display("[TB] scenario 1: full readback");
    applyStimulus(9);
    wait_done("s1");
    checkOutput("s1 checksum", 32'(checksum), 32'(FULL_CSUM));
    checkOutput("s1 busy after done", 32'(busy), 32'd0);
    checkOutput("s1 queue drained", 32'(exp_q.size()), 32'd0);
    tick();

    $display("[TB] scenario 2: timing");
    for (int i = 0; i < 9; i++) exp_q.push_back({(i == 8), exp_words[i]});
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("s2 c1 wl_sel", 32'(wl_sel), 32'h1);
    checkOutput("s2 c1 wl_rd_en", 32'(wl_rd_en), 32'd1);
    checkOutput("s2 c1 busy", 32'(busy), 32'd1);
    checkOutput("s2 c1 out_valid", 32'(out_valid), 32'd0);
    tick();
    checkOutput("s2 c2 wl_sel", 32'(wl_sel), 32'h1);
    tick();
    checkOutput("s2 c3 out_valid", 32'(out_valid), 32'd1);
    checkOutput("s2 c3 wl_sel", 32'(wl_sel), 32'h0);
    tick();
    tick();
    tick();
    checkOutput("s2 c6 wl_sel", 32'(wl_sel), 32'h2);
    checkOutput("s2 c6 wl_rd_en", 32'(wl_rd_en), 32'd1);
    tick();
    checkOutput("s2 c7 wl_sel", 32'(wl_sel), 32'h2);
    tick();
    checkOutput("s2 c8 wl_sel", 32'(wl_sel), 32'h0);
    wait_done("s2");
    checkOutput("s2 busy at done", 32'(busy), 32'd0);
    checkOutput("s2 checksum", 32'(checksum), 32'(FULL_CSUM));
    tick();

    $display("[TB] scenario 3: backpressure");
    bp_mode = 1'b1;
    applyStimulus(9);
    wait_done("s3");
    bp_mode   = 1'b0;
    out_ready = 1'b1;
    checkOutput("s3 checksum", 32'(checksum), 32'(FULL_CSUM));
    checkOutput("s3 queue drained", 32'(exp_q.size()), 32'd0);
    tick();

    $display("[TB] scenario 4: start while busy");
    applyStimulus(9);
    begin
      int n = 0;
      while (!done && n < 2000) begin
        start = (n % 3 == 1);
        tick();
        start = 1'b0;
        n++;
      end
    end
    checkOutput("s4 done seen", 32'(done), 32'd1);
    checkOutput("s4 checksum", 32'(checksum), 32'(FULL_CSUM));
    checkOutput("s4 queue drained", 32'(exp_q.size()), 32'd0);
    tick();
    checkOutput("s4 idle after done", 32'(busy), 32'd0);
    applyStimulus(9);
    wait_done("s4b");
    checkOutput("s4b checksum restart", 32'(checksum), 32'(FULL_CSUM));
    tick();

    $display("[TB] scenario 5: abort");
    applyStimulus(3);
    wait_row1("s5");
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
    end
    checkOutput("s5 valid on row1 word0", 32'(out_valid), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("s5 out_valid", 32'(out_valid), 32'd0);
    checkOutput("s5 wl_sel", 32'(wl_sel), 32'd0);
    checkOutput("s5 busy", 32'(busy), 32'd0);
    checkOutput("s5 done", 32'(done), 32'd0);
    checkOutput("s5 out_data", 32'(out_data), 32'd0);
    checkOutput("s5 checksum", 32'(checksum), 32'(ROW0_CSUM));
    tick();
    tick();
    checkOutput("s5 still idle", 32'(busy), 32'd0);
    checkOutput("s5 queue drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] scenario 6: reset mid-run");
    applyStimulus(9);
    wait_row1("s6");
    #2;
    global_resetn = 1'b0;
    #1;
    checkOutput("s6 async wl_sel", 32'(wl_sel), 32'd0);
    checkOutput("s6 async wl_rd_en", 32'(wl_rd_en), 32'd0);
    checkOutput("s6 async busy", 32'(busy), 32'd0);
    checkOutput("s6 async checksum", 32'(checksum), 32'd0);
    exp_q.delete();
    tick();
    global_resetn = 1'b1;
    tick();
    applyStimulus(9);
    wait_done("s6b");
    checkOutput("s6b checksum", 32'(checksum), 32'(FULL_CSUM));
    checkOutput("s6b queue drained", 32'(exp_q.size()), 32'd0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
